pipe_de_stall: RTL and testbench
================================

PIPE_DE_STALL -- requirements
Module: pipe_de_stall

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and reset are the only clock and reset ports, and reset low clears all state immediately.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 ir_D  input  32  instruction in the D stage.
REQ-005 pc_D  input  32  PC of the D-stage instruction.
REQ-006 rs_val_D, rt_val_D  input  32 each  D-stage operands, already forwarded.
REQ-007 ext_D  input  32  extended immediate.
REQ-008 stall  output  1  combinational hazard stall; the PC and F/D enables are ~stall.
REQ-009 ir_E, pc_E, rs_val_E, rt_val_E, ext_E  output  32 each  registered E-stage copies.
REQ-010 dest_E, dest_M  output  5 each  destination register of the E-stage and M-stage instruction; 0 means no write.
REQ-011 tnew_E, tnew_M  output  2 each  cycles until the E-stage or M-stage result can be forwarded.

Function
REQ-012 Supported set: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, nop (0x00000000); any other encoding SHALL decode as nop.
REQ-013 Destination decode:
 - addu/subu: rd.
 - ori/lui/lw: rt.
 - jal: 31.
 - all others: 0.
REQ-014 Tuse decode:
 - beq: rs 0, rt 0.
 - jr: rs 0.
 - addu/subu: rs 1, rt 1.
 - ori/lw/sw: rs 1.
 - sw: rt 2.
 - an operand with no Tuse is unused.
REQ-015 Tnew loaded into E:
 - addu/subu/ori/lui: 1.
 - lw: 2.
 - jal: 2.
 - others: 0.
REQ-016 stall SHALL be 1 when either of these holds, and 0 otherwise:
 - (a) a used D operand is nonzero, equals dest_E, and its Tuse < tnew_E.
 - (b) a used D operand is nonzero, equals dest_M, and its Tuse < tnew_M.
REQ-017 Register $0 SHALL never cause a stall.
REQ-018 On each rising edge with stall=0, the E registers SHALL load ir_D, pc_D, rs_val_D, rt_val_D, ext_D, the decoded dest and the decoded Tnew.
REQ-019 On each rising edge with stall=1, the E registers SHALL load a bubble: ir 0, pc pc_D, all values 0, dest 0, tnew 0.
REQ-020 On every rising edge, dest_M SHALL load dest_E, and tnew_M SHALL load tnew_E-1 saturating at 0; M never stalls.
REQ-021 Latency: D to E is exactly one cycle when not stalled.
REQ-022 Stall duration: lw/jal followed by a Tuse-0 consumer stalls 2 cycles; cal followed by a Tuse-0 consumer stalls 1 cycle; lw followed by a Tuse-1 consumer stalls 1 cycle.
REQ-023 Tnew arithmetic SHALL be unsigned 2-bit and never wrap below 0.

Reset
REQ-024 While reset=0, all registered outputs SHALL be 0 (ir_E is nop) and stall SHALL be 0.
REQ-025 Reset asserted mid-stall SHALL discard the pending hazard; the first edge after release SHALL load ir_D normally.

Structure
REQ-026 Opcode/funct constants SHALL come from the shared const.v define file; Tuse/Tnew values SHALL be named defines in the same file.
REQ-027 One combinational sub-module, instr_decode, SHALL map an instruction to {dest, tuse_rs, tuse_rt, rs_used, rt_used, tnew}.
REQ-028 instr_decode SHALL be instantiated once for D.

Verification
REQ-029 Scenario: lw $1,0($0) then beq $1,$2 -> stall=1 for 2 cycles; ir_E=0 for both bubbles; beq enters E on the third edge.
REQ-030 Scenario: addu $3,$1,$2 then jr $3 -> 1 stall cycle; tnew_M=0 when jr leaves D.
REQ-031 Scenario: lw $4 then addu $5,$4,$4 -> 1 stall; lw then sw $4 (rt only, Tuse 2) -> no stall.
REQ-032 Scenario: ori $0,$0,5 then beq $0,$0 -> stall=0 every cycle.
REQ-033 Scenario: jal then jr $31 -> 2 stalls; dest_E=31 and tnew_E=2, then dest_M=31 and tnew_M=1.
REQ-034 Scenario: reset pulled low during the second lw stall cycle -> all outputs 0 asynchronously; after release, ir_D reaches ir_E on the first edge.

Source files
------------

// File: rtl/pipe_de_stall_pkg.sv
// Shared opcode/funct encodings, Tuse/Tnew values and decode helpers for the
// D->E stage register and hazard-stall logic.
package pipe_de_stall_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_JR      = 6'h08;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [4:0] REG_RA     = 5'd31;

    localparam logic [1:0] TUSE_0     = 2'd0;
    localparam logic [1:0] TUSE_1     = 2'd1;
    localparam logic [1:0] TUSE_2     = 2'd2;

    localparam logic [1:0] TNEW_NONE  = 2'd0;
    localparam logic [1:0] TNEW_CAL   = 2'd1;
    localparam logic [1:0] TNEW_LW    = 2'd2;
    localparam logic [1:0] TNEW_JAL   = 2'd2;

    typedef enum logic [3:0] {
        K_NOP,
        K_ADDU,
        K_SUBU,
        K_ORI,
        K_LUI,
        K_LW,
        K_SW,
        K_BEQ,
        K_J,
        K_JAL,
        K_JR
    } instr_kind_e;

    typedef struct packed {
        logic [4:0] dest;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic       rs_used;
        logic       rt_used;
        logic [1:0] tnew;
    } decode_t;

    // Anything outside the supported set falls through to K_NOP.
    function automatic instr_kind_e classify(input logic [31:0] ir);
        instr_kind_e kind;
        kind = K_NOP;
        case (ir[31:26])
            OP_SPECIAL: begin
                case (ir[5:0])
                    FN_ADDU: kind = K_ADDU;
                    FN_SUBU: kind = K_SUBU;
                    FN_JR:   kind = K_JR;
                    default: kind = K_NOP;
                endcase
            end
            OP_ORI:  kind = K_ORI;
            OP_LUI:  kind = K_LUI;
            OP_LW:   kind = K_LW;
            OP_SW:   kind = K_SW;
            OP_BEQ:  kind = K_BEQ;
            OP_J:    kind = K_J;
            OP_JAL:  kind = K_JAL;
            default: kind = K_NOP;
        endcase
        return kind;
    endfunction

    function automatic logic [1:0] tnew_age(input logic [1:0] tnew);
        return (tnew == TNEW_NONE) ? TNEW_NONE : tnew - 2'd1;
    endfunction

endpackage

// File: rtl/pipe_de_stall_instr_decode.sv
// Combinational decode of one instruction into destination register,
// per-operand Tuse and the Tnew it carries into E.
module instr_decode
    import pipe_de_stall_pkg::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  dest,
    output logic [1:0]  tuse_rs,
    output logic [1:0]  tuse_rt,
    output logic        rs_used,
    output logic        rt_used,
    output logic [1:0]  tnew
);

    instr_kind_e kind;
    logic [4:0]  rt;
    logic [4:0]  rd;

    assign kind = classify(ir);
    assign rt   = ir[20:16];
    assign rd   = ir[15:11];

    always_comb begin
        dest    = REG_ZERO;
        tuse_rs = TUSE_0;
        tuse_rt = TUSE_0;
        rs_used = 1'b0;
        rt_used = 1'b0;
        tnew    = TNEW_NONE;
        case (kind)
            K_ADDU, K_SUBU: begin
                dest    = rd;
                rs_used = 1'b1;
                rt_used = 1'b1;
                tuse_rs = TUSE_1;
                tuse_rt = TUSE_1;
                tnew    = TNEW_CAL;
            end
            K_ORI: begin
                dest    = rt;
                rs_used = 1'b1;
                tuse_rs = TUSE_1;
                tnew    = TNEW_CAL;
            end
            K_LUI: begin
                dest    = rt;
                tnew    = TNEW_CAL;
            end
            K_LW: begin
                dest    = rt;
                rs_used = 1'b1;
                tuse_rs = TUSE_1;
                tnew    = TNEW_LW;
            end
            K_SW: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
                tuse_rs = TUSE_1;
                tuse_rt = TUSE_2;
            end
            K_BEQ: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
                tuse_rs = TUSE_0;
                tuse_rt = TUSE_0;
            end
            K_JR: begin
                rs_used = 1'b1;
                tuse_rs = TUSE_0;
            end
            K_JAL: begin
                dest    = REG_RA;
                tnew    = TNEW_JAL;
            end
            default: begin
                dest    = REG_ZERO;
            end
        endcase
    end

endmodule

// File: rtl/pipe_de_stall.sv
// D->E pipeline register with Tuse/Tnew hazard stall; injects a bubble into E
// while stalled and ages the M-stage Tnew every cycle.
module pipe_de_stall
    import pipe_de_stall_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir_D,
    input  logic [31:0] pc_D,
    input  logic [31:0] rs_val_D,
    input  logic [31:0] rt_val_D,
    input  logic [31:0] ext_D,
    output logic        stall,
    output logic [31:0] ir_E,
    output logic [31:0] pc_E,
    output logic [31:0] rs_val_E,
    output logic [31:0] rt_val_E,
    output logic [31:0] ext_E,
    output logic [4:0]  dest_E,
    output logic [4:0]  dest_M,
    output logic [1:0]  tnew_E,
    output logic [1:0]  tnew_M
);

    logic [4:0] dest_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic       rs_used_D;
    logic       rt_used_D;
    logic [1:0] tnew_D;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic       rs_hazard;
    logic       rt_hazard;

    assign rs_D = ir_D[25:21];
    assign rt_D = ir_D[20:16];

    instr_decode u_decode_d (
        .ir      (ir_D),
        .dest    (dest_D),
        .tuse_rs (tuse_rs_D),
        .tuse_rt (tuse_rt_D),
        .rs_used (rs_used_D),
        .rt_used (rt_used_D),
        .tnew    (tnew_D)
    );

    // A producer with dest 0 never writes, so the nonzero check also masks
    // bubbles and non-writing instructions in E/M.
    always_comb begin
        rs_hazard = 1'b0;
        rt_hazard = 1'b0;
        if (rs_used_D && (rs_D != REG_ZERO)) begin
            rs_hazard = ((rs_D == dest_E) && (tuse_rs_D < tnew_E)) ||
                        ((rs_D == dest_M) && (tuse_rs_D < tnew_M));
        end
        if (rt_used_D && (rt_D != REG_ZERO)) begin
            rt_hazard = ((rt_D == dest_E) && (tuse_rt_D < tnew_E)) ||
                        ((rt_D == dest_M) && (tuse_rt_D < tnew_M));
        end
    end

    assign stall = reset && (rs_hazard || rt_hazard);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_E     <= 32'd0;
            pc_E     <= 32'd0;
            rs_val_E <= 32'd0;
            rt_val_E <= 32'd0;
            ext_E    <= 32'd0;
            dest_E   <= REG_ZERO;
            tnew_E   <= TNEW_NONE;
        end else if (stall) begin
            ir_E     <= 32'd0;
            pc_E     <= pc_D;
            rs_val_E <= 32'd0;
            rt_val_E <= 32'd0;
            ext_E    <= 32'd0;
            dest_E   <= REG_ZERO;
            tnew_E   <= TNEW_NONE;
        end else begin
            ir_E     <= ir_D;
            pc_E     <= pc_D;
            rs_val_E <= rs_val_D;
            rt_val_E <= rt_val_D;
            ext_E    <= ext_D;
            dest_E   <= dest_D;
            tnew_E   <= tnew_D;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dest_M <= REG_ZERO;
            tnew_M <= TNEW_NONE;
        end else begin
            dest_M <= dest_E;
            tnew_M <= tnew_age(tnew_E);
        end
    end

endmodule

// File: tb/tb_pipe_de_stall.sv
// Directed hazard scenarios for pipe_de_stall with hand-computed expectations.
module tb_pipe_de_stall;

    logic        clk;
    logic        reset;
    logic [31:0] ir_D, pc_D, rs_val_D, rt_val_D, ext_D;
    logic        stall;
    logic [31:0] ir_E, pc_E, rs_val_E, rt_val_E, ext_E;
    logic [4:0]  dest_E, dest_M;
    logic [1:0]  tnew_E, tnew_M;

    int n_cmp = 0;
    int n_err = 0;

    pipe_de_stall dut (
        .clk      (clk),
        .reset    (reset),
        .ir_D     (ir_D),
        .pc_D     (pc_D),
        .rs_val_D (rs_val_D),
        .rt_val_D (rt_val_D),
        .ext_D    (ext_D),
        .stall    (stall),
        .ir_E     (ir_E),
        .pc_E     (pc_E),
        .rs_val_E (rs_val_E),
        .rt_val_E (rt_val_E),
        .ext_E    (ext_E),
        .dest_E   (dest_E),
        .dest_M   (dest_M),
        .tnew_E   (tnew_E),
        .tnew_M   (tnew_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a D-stage instruction; operand values are tagged from the PC.
    task automatic drive(input logic [31:0] ir, input logic [31:0] pc);
        ir_D     = ir;
        pc_D     = pc;
        rs_val_D = pc ^ 32'hA000_0000;
        rt_val_D = pc ^ 32'hB000_0000;
        ext_D    = pc ^ 32'hC000_0000;
        #1;
    endtask

    logic [31:0] lw1, beq12, addu3, jr3, lw4, addu5, sw4, ori0, beq00, jal1, jr31, bad, lui6;

    initial begin
        lw1   = i_ins(6'h23, 5'd0, 5'd1, 16'h0000);
        beq12 = i_ins(6'h04, 5'd1, 5'd2, 16'h0003);
        addu3 = r_ins(6'h21, 5'd1, 5'd2, 5'd3);
        jr3   = r_ins(6'h08, 5'd3, 5'd0, 5'd0);
        lw4   = i_ins(6'h23, 5'd0, 5'd4, 16'h0008);
        addu5 = r_ins(6'h21, 5'd4, 5'd4, 5'd5);
        sw4   = i_ins(6'h2b, 5'd0, 5'd4, 16'h0004);
        ori0  = i_ins(6'h0d, 5'd0, 5'd0, 16'h0005);
        beq00 = i_ins(6'h04, 5'd0, 5'd0, 16'h0001);
        jal1  = {6'h03, 26'h0000040};
        jr31  = r_ins(6'h08, 5'd31, 5'd0, 5'd0);
        bad   = i_ins(6'h3f, 5'd1, 5'd7, 16'h1234);
        lui6  = i_ins(6'h0f, 5'd0, 5'd6, 16'hBEEF);

        reset = 1'b0;
        ir_D = 32'd0; pc_D = 32'd0; rs_val_D = 32'd0; rt_val_D = 32'd0; ext_D = 32'd0;
        #2;
        drive(lw1, 32'h100);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ir_E", ir_E, 32'd0);
        chk("rst_dest_M", {27'd0, dest_M}, 32'd0);
        chk("rst_tnew_E", {30'd0, tnew_E}, 32'd0);
        tick();
        chk("rst_hold_ir_E", ir_E, 32'd0);
        reset = 1'b1;

        // lw $1 then beq $1,$2: two bubbles
        tick();
        chk("lw_ir_E", ir_E, lw1);
        chk("lw_pc_E", pc_E, 32'h100);
        chk("lw_dest_E", {27'd0, dest_E}, 32'd1);
        chk("lw_tnew_E", {30'd0, tnew_E}, 32'd2);
        drive(beq12, 32'h104);
        chk("beq_stall1", {31'd0, stall}, 32'd1);
        tick();
        chk("beq_bub1_ir_E", ir_E, 32'd0);
        chk("beq_bub1_pc_E", pc_E, 32'h104);
        chk("beq_bub1_rs_E", rs_val_E, 32'd0);
        chk("beq_dest_M", {27'd0, dest_M}, 32'd1);
        chk("beq_tnew_M", {30'd0, tnew_M}, 32'd1);
        chk("beq_stall2", {31'd0, stall}, 32'd1);
        tick();
        chk("beq_bub2_ir_E", ir_E, 32'd0);
        chk("beq_bub2_tnew_M", {30'd0, tnew_M}, 32'd0);
        chk("beq_stall3", {31'd0, stall}, 32'd0);
        tick();
        chk("beq_ir_E", ir_E, beq12);
        chk("beq_rs_E", rs_val_E, 32'hA000_0104);
        chk("beq_ext_E", ext_E, 32'hC000_0104);
        chk("beq_dest_E", {27'd0, dest_E}, 32'd0);

        // addu $3 then jr $3: one bubble
        drive(addu3, 32'h108);
        chk("addu_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("addu_tnew_E", {30'd0, tnew_E}, 32'd1);
        chk("addu_dest_E", {27'd0, dest_E}, 32'd3);
        drive(jr3, 32'h10c);
        chk("jr3_stall1", {31'd0, stall}, 32'd1);
        tick();
        chk("jr3_stall2", {31'd0, stall}, 32'd0);
        chk("jr3_dest_M", {27'd0, dest_M}, 32'd3);
        chk("jr3_tnew_M", {30'd0, tnew_M}, 32'd0);
        tick();
        chk("jr3_ir_E", ir_E, jr3);

        // lw $4 then addu $5,$4,$4: one bubble; then lw/sw no stall
        drive(lw4, 32'h110);
        chk("lw4_stall", {31'd0, stall}, 32'd0);
        tick();
        drive(addu5, 32'h114);
        chk("addu5_stall1", {31'd0, stall}, 32'd1);
        tick();
        chk("addu5_stall2", {31'd0, stall}, 32'd0);
        tick();
        chk("addu5_ir_E", ir_E, addu5);
        chk("addu5_dest_E", {27'd0, dest_E}, 32'd5);
        drive(lw4, 32'h118);
        tick();
        drive(sw4, 32'h11c);
        chk("sw4_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("sw4_ir_E", ir_E, sw4);
        chk("sw4_dest_E", {27'd0, dest_E}, 32'd0);
        chk("sw4_dest_M", {27'd0, dest_M}, 32'd4);
        chk("sw4_tnew_M", {30'd0, tnew_M}, 32'd1);

        // ori $0 then beq $0,$0: $0 never stalls
        drive(ori0, 32'h120);
        chk("ori0_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("ori0_dest_E", {27'd0, dest_E}, 32'd0);
        chk("ori0_tnew_E", {30'd0, tnew_E}, 32'd1);
        drive(beq00, 32'h124);
        chk("beq00_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("beq00_ir_E", ir_E, beq00);

        // lui and unsupported encoding
        drive(lui6, 32'h128);
        tick();
        chk("lui_dest_E", {27'd0, dest_E}, 32'd6);
        chk("lui_tnew_E", {30'd0, tnew_E}, 32'd1);
        drive(bad, 32'h12c);
        chk("bad_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("bad_ir_E", ir_E, bad);
        chk("bad_dest_E", {27'd0, dest_E}, 32'd0);
        chk("bad_tnew_E", {30'd0, tnew_E}, 32'd0);

        // jal then jr $31: two bubbles
        drive(jal1, 32'h130);
        chk("jal_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("jal_dest_E", {27'd0, dest_E}, 32'd31);
        chk("jal_tnew_E", {30'd0, tnew_E}, 32'd2);
        drive(jr31, 32'h134);
        chk("jr31_stall1", {31'd0, stall}, 32'd1);
        tick();
        chk("jr31_stall2", {31'd0, stall}, 32'd1);
        chk("jr31_dest_M", {27'd0, dest_M}, 32'd31);
        chk("jr31_tnew_M", {30'd0, tnew_M}, 32'd1);
        tick();
        chk("jr31_stall3", {31'd0, stall}, 32'd0);
        tick();
        chk("jr31_ir_E", ir_E, jr31);

        // reset during the second lw stall cycle
        drive(lw1, 32'h138);
        tick();
        drive(beq12, 32'h13c);
        tick();
        chk("mid_stall_pre", {31'd0, stall}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_pc_E", pc_E, 32'd0);
        chk("mid_rst_dest_M", {27'd0, dest_M}, 32'd0);
        chk("mid_rst_tnew_M", {30'd0, tnew_M}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("post_rst_ir_E", ir_E, beq12);
        chk("post_rst_pc_E", pc_E, 32'h13c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
